// File: rtl/upstream_write_arbiter_if.sv
// Request/memory bus for upstream_write_arbiter: two write requesters on one side,
// the upstream limit memory on the other.
interface upstream_write_arbiter_if #(
   parameter int IDX_W  = 7,
   parameter int DATA_W = 32
);
   logic [1:0]          req_valid;
   logic [2*IDX_W-1:0]  req_index;
   logic [2*DATA_W-1:0] req_data;
   logic [1:0]          req_change_max;
   logic [1:0]          req_ready;
   logic [1:0]          req_done;
   logic [1:0]          req_err;

   logic                mem_rw;
   logic [IDX_W-1:0]    mem_index;
   logic [DATA_W-1:0]   mem_data;
   logic                mem_change_max;
   logic                mem_written;

   // slave: the arbiter itself
   modport slave (
      input  req_valid, req_index, req_data, req_change_max, mem_written,
      output req_ready, req_done, req_err,
      output mem_rw, mem_index, mem_data, mem_change_max
   );

   // master: the requesters plus the memory
   modport master (
      output req_valid, req_index, req_data, req_change_max, mem_written,
      input  req_ready, req_done, req_err,
      input  mem_rw, mem_index, mem_data, mem_change_max
   );
endinterface

// File: rtl/upstream_write_arbiter.sv
// Round-robin arbiter for two write requesters sharing one upstream memory port.
// Optional WAIT-state abort timer enabled with macro ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transaction; grant a valid requester and latch its write
// S_ISSUE | mem_rw raised, seen_low cleared
// S_WAIT  | mem_rw held until mem_written goes low then high (or timeout)
// S_DONE  | mem_rw dropped, req_done pulsed to the granted requester
module upstream_write_arbiter #(
   parameter int IDX_W   = 7,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   upstream_write_arbiter_if.slave   bus,
   output logic                      busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   if (TIMEOUT < 1) begin : g_tmo_chk
      $error("TIMEOUT must be at least 1");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_grant;
   logic                r_gnt;
   logic                w_gnt;
   logic                r_seen_low;
   logic                w_seen_low_nxt;
   logic                w_accept;
   logic                w_abort;
   logic                w_mem_rw;
   logic [1:0]          w_ready;
   logic [1:0]          w_done;

   logic [IDX_W-1:0]    r_mem_index;
   logic [DATA_W-1:0]   r_mem_data;
   logic                r_mem_change_max;
   logic [IDX_W-1:0]    w_sel_index;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_change_max;

   // Round-robin: a lone request always wins, contention goes to the other side.
   always_comb begin
      w_gnt = r_last_grant;
      case (bus.req_valid)
         2'b01:   w_gnt = 1'b0;
         2'b10:   w_gnt = 1'b1;
         2'b11:   w_gnt = ~r_last_grant;
         default: w_gnt = r_last_grant;
      endcase
   end

   assign w_sel_index      = w_gnt ? bus.req_index[2*IDX_W-1:IDX_W]   : bus.req_index[IDX_W-1:0];
   assign w_sel_data       = w_gnt ? bus.req_data[2*DATA_W-1:DATA_W]  : bus.req_data[DATA_W-1:0];
   assign w_sel_change_max = w_gnt ? bus.req_change_max[1]            : bus.req_change_max[0];

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0]    r_tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Abort on the TIMEOUT-th WAIT cycle unless that same cycle completes the write.
   assign w_abort = (r_state == S_WAIT)
                  && !(r_seen_low && bus.mem_written)
                  && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
   assign bus.req_err = (!rst && w_abort) ? (2'b01 << r_gnt) : 2'b00;
`else
   assign w_abort     = 1'b0;
   assign bus.req_err = 2'b00;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_seen_low_nxt = r_seen_low;
      w_accept       = 1'b0;
      w_mem_rw       = 1'b0;
      w_ready        = 2'b00;
      w_done         = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (|bus.req_valid) begin
               w_accept    = 1'b1;
               w_ready     = 2'b01 << w_gnt;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_mem_rw       = 1'b1;
            w_seen_low_nxt = 1'b0;
            w_state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            if (w_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_mem_rw = 1'b1;
               // A high level before any low is the previous write's ack.
               if (!bus.mem_written) begin
                  w_seen_low_nxt = 1'b1;
               end else if (r_seen_low) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_done      = 2'b01 << r_gnt;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_last_grant     <= 1'b1;
         r_gnt            <= 1'b0;
         r_seen_low       <= 1'b0;
         r_mem_index      <= '0;
         r_mem_data       <= '0;
         r_mem_change_max <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_seen_low <= w_seen_low_nxt;
         if (w_accept) begin
            r_last_grant     <= w_gnt;
            r_gnt            <= w_gnt;
            r_mem_index      <= w_sel_index;
            r_mem_data       <= w_sel_data;
            r_mem_change_max <= w_sel_change_max;
         end
      end
   end

   // Pulses are suppressed while rst is high so an aborted transaction never reports.
   assign bus.req_ready      = rst ? 2'b00 : w_ready;
   assign bus.req_done       = rst ? 2'b00 : w_done;
   assign bus.mem_rw         = w_mem_rw;
   assign bus.mem_index      = r_mem_index;
   assign bus.mem_data       = r_mem_data;
   assign bus.mem_change_max = r_mem_change_max;
   assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_upstream_write_arbiter.sv
// Directed bench for upstream_write_arbiter; timeout scenario follows ARB_TIMEOUT_EN.
module tb_upstream_write_arbiter;
   localparam int IDX_W   = 7;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 15;

   logic clk;
   logic rst;
   logic busy;
   int   checks;
   int   errors;

   upstream_write_arbiter_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

   upstream_write_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input logic [1:0] valid,
                          input logic [IDX_W-1:0] idx0, input logic [DATA_W-1:0] dat0, input logic cm0,
                          input logic [IDX_W-1:0] idx1, input logic [DATA_W-1:0] dat1, input logic cm1);
      bus.req_valid      = valid;
      bus.req_index      = {idx1, idx0};
      bus.req_data       = {dat1, dat0};
      bus.req_change_max = {cm1, cm0};
   endtask

   // Called in ISSUE: memory drops written, holds it low for n_low WAIT cycles, then raises it.
   task automatic finish_write(input int n_low);
      bus.mem_written = 1'b0;
      repeat (n_low + 1) tick();
      bus.mem_written = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(2'b01, 7'd5, 32'h1234, 1'b1, 7'd6, 32'h5678, 1'b1);
      bus.mem_written = 1'b1;
      repeat (2) tick();
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready); end
      checks++; if (bus.mem_rw !== 1'b0) begin errors++; $display("FAIL reset_mem_rw: got %b expected 0", bus.mem_rw); end
      checks++; if (bus.mem_index !== 7'd0) begin errors++; $display("FAIL reset_mem_index: got %0d expected 0", bus.mem_index); end
      checks++; if (bus.mem_data !== 32'd0) begin errors++; $display("FAIL reset_mem_data: got %h expected 0", bus.mem_data); end
      checks++; if (bus.mem_change_max !== 1'b0) begin errors++; $display("FAIL reset_mem_cm: got %b expected 0", bus.mem_change_max); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({bus.req_done, bus.req_err} !== 4'b0000) begin errors++; $display("FAIL reset_done_err: got %b expected 0000", {bus.req_done, bus.req_err}); end
      set_req(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_write();
      set_req(2'b01, 7'd5, 32'h0000_0010, 1'b0, 7'd0, 32'd0, 1'b0);
      settle();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", bus.req_ready); end
      tick();
      set_req(2'b00, 7'd0, 32'hDEAD_BEEF, 1'b1, 7'd0, 32'd0, 1'b0);
      bus.mem_written = 1'b0;
      settle();
      checks++; if (bus.mem_rw !== 1'b1) begin errors++; $display("FAIL single_issue_rw: got %b expected 1", bus.mem_rw); end
      checks++; if (bus.mem_index !== 7'd5) begin errors++; $display("FAIL single_index: got %0d expected 5", bus.mem_index); end
      checks++; if (bus.mem_data !== 32'h0000_0010) begin errors++; $display("FAIL single_data: got %h expected 00000010", bus.mem_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      tick();
      tick();
      checks++; if ((bus.mem_rw !== 1'b1) || (bus.req_done !== 2'b00)) begin errors++; $display("FAIL single_wait: rw %b done %b expected rw 1 done 00", bus.mem_rw, bus.req_done); end
      tick();
      bus.mem_written = 1'b1;
      settle();
      checks++; if (bus.req_done !== 2'b00) begin errors++; $display("FAIL single_early_done: got %b expected 00", bus.req_done); end
      tick();
      checks++; if (bus.req_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b expected 01", bus.req_done); end
      checks++; if (bus.mem_rw !== 1'b0) begin errors++; $display("FAIL single_done_rw: got %b expected 0", bus.mem_rw); end
      tick();
      checks++; if ((busy !== 1'b0) || (bus.req_done !== 2'b00)) begin errors++; $display("FAIL single_after: busy %b done %b expected 0 00", busy, bus.req_done); end
   endtask

   task automatic test_contention();
      // Reset first so last_grant is back to 1 and requester 0 must win.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(2'b11, 7'd3, 32'h0000_0003, 1'b0, 7'd9, 32'h0000_0009, 1'b0);
      settle();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b expected 01", bus.req_ready); end
      tick();
      settle();
      checks++; if ((bus.req_ready !== 2'b00) || (bus.mem_index !== 7'd3)) begin errors++; $display("FAIL cont_issue: ready %b index %0d expected 00 3", bus.req_ready, bus.mem_index); end
      bus.mem_written = 1'b0;
      tick();
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_wait_ready: got %b expected 00", bus.req_ready); end
      tick();
      bus.mem_written = 1'b1;
      tick();
      checks++; if ((bus.req_done !== 2'b01) || (bus.req_ready !== 2'b00)) begin errors++; $display("FAIL cont_first_done: done %b ready %b expected 01 00", bus.req_done, bus.req_ready); end
      tick();
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b expected 10", bus.req_ready); end
      tick();
      set_req(2'b00, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0);
      checks++; if (bus.mem_index !== 7'd9) begin errors++; $display("FAIL cont_second_index: got %0d expected 9", bus.mem_index); end
      finish_write(1);
      checks++; if (bus.req_done !== 2'b10) begin errors++; $display("FAIL cont_second_done: got %b expected 10", bus.req_done); end
      tick();
   endtask

   task automatic test_stale_ack();
      bus.mem_written = 1'b1;
      set_req(2'b01, 7'd11, 32'h0000_0022, 1'b0, 7'd0, 32'd0, 1'b0);
      settle();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL stale_ready: got %b expected 01", bus.req_ready); end
      tick();
      set_req(2'b00, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0);
      tick();
      checks++; if ((bus.req_done !== 2'b00) || (bus.mem_rw !== 1'b1)) begin errors++; $display("FAIL stale_wait1: done %b rw %b expected 00 1", bus.req_done, bus.mem_rw); end
      tick();
      bus.mem_written = 1'b0;
      settle();
      checks++; if ((bus.req_done !== 2'b00) || (bus.mem_rw !== 1'b1)) begin errors++; $display("FAIL stale_ignored: done %b rw %b expected 00 1", bus.req_done, bus.mem_rw); end
      tick();
      bus.mem_written = 1'b1;
      tick();
      checks++; if (bus.req_done !== 2'b01) begin errors++; $display("FAIL stale_done: got %b expected 01", bus.req_done); end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      set_req(2'b01, 7'd17, 32'h0000_0005, 1'b0, 7'd0, 32'd0, 1'b0);
      tick();
      set_req(2'b00, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0);
      bus.mem_written = 1'b0;
      tick();
      bus.mem_written = 1'b1;
      rst = 1'b1;
      settle();
      checks++; if ({bus.req_done, bus.req_err} !== 4'b0000) begin errors++; $display("FAIL rstwait_pulse: got %b expected 0000", {bus.req_done, bus.req_err}); end
      tick();
      rst = 1'b0;
      settle();
      checks++; if ((bus.mem_rw !== 1'b0) || (busy !== 1'b0)) begin errors++; $display("FAIL rstwait_idle: rw %b busy %b expected 0 0", bus.mem_rw, busy); end
      checks++; if ({bus.req_done, bus.req_err} !== 4'b0000) begin errors++; $display("FAIL rstwait_after_pulse: got %b expected 0000", {bus.req_done, bus.req_err}); end
      set_req(2'b11, 7'd1, 32'h0000_0001, 1'b0, 7'd2, 32'h0000_0002, 1'b0);
      settle();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstwait_regrant: got %b expected 01", bus.req_ready); end
      tick();
      set_req(2'b00, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0);
      finish_write(1);
      checks++; if (bus.req_done !== 2'b01) begin errors++; $display("FAIL rstwait_done: got %b expected 01", bus.req_done); end
      tick();
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      set_req(2'b01, 7'd40, 32'h0000_0007, 1'b0, 7'd0, 32'd0, 1'b0);
      tick();
      set_req(2'b00, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0);
      bus.mem_written = 1'b0;
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < TIMEOUT; i++) begin
         tick();
         if ((bus.req_err !== 2'b00) || (bus.req_done !== 2'b00) || (bus.mem_rw !== 1'b1)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL tmo_early: %0d bad WAIT cycles expected 0", bad); end
      tick();
      checks++; if ((bus.req_err !== 2'b01) || (bus.req_done !== 2'b00)) begin errors++; $display("FAIL tmo_err: err %b done %b expected 01 00", bus.req_err, bus.req_done); end
      checks++; if (bus.mem_rw !== 1'b0) begin errors++; $display("FAIL tmo_rw: got %b expected 0", bus.mem_rw); end
      tick();
      checks++; if ((busy !== 1'b0) || (bus.req_err !== 2'b00)) begin errors++; $display("FAIL tmo_idle: busy %b err %b expected 0 00", busy, bus.req_err); end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if ((busy !== 1'b1) || (bus.req_err !== 2'b00) || (bus.req_done !== 2'b00) || (bus.mem_rw !== 1'b1)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL notmo_hold: %0d bad cycles expected 0", bad); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notmo_reset: busy %b expected 0", busy); end
`endif
      bus.mem_written = 1'b1;
      tick();
   endtask

   task automatic test_max_update();
      set_req(2'b10, 7'd0, 32'd0, 1'b0, 7'd121, 32'h0064_0000, 1'b1);
      settle();
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL max_ready: got %b expected 10", bus.req_ready); end
      tick();
      // Scramble the request lines to prove the memory side is latched.
      set_req(2'b00, 7'd3, 32'hFFFF_FFFF, 1'b0, 7'd4, 32'h1111_1111, 1'b0);
      bus.mem_written = 1'b0;
      settle();
      checks++; if ({bus.mem_index, bus.mem_data, bus.mem_change_max} !== {7'd121, 32'h0064_0000, 1'b1}) begin errors++; $display("FAIL max_issue: idx %0d data %h cm %b expected 121 00640000 1", bus.mem_index, bus.mem_data, bus.mem_change_max); end
      tick();
      checks++; if ({bus.mem_index, bus.mem_data, bus.mem_change_max} !== {7'd121, 32'h0064_0000, 1'b1}) begin errors++; $display("FAIL max_wait: idx %0d data %h cm %b expected 121 00640000 1", bus.mem_index, bus.mem_data, bus.mem_change_max); end
      tick();
      bus.mem_written = 1'b1;
      tick();
      checks++; if (bus.req_done !== 2'b10) begin errors++; $display("FAIL max_done: got %b expected 10", bus.req_done); end
      checks++; if ({bus.mem_index, bus.mem_data, bus.mem_change_max} !== {7'd121, 32'h0064_0000, 1'b1}) begin errors++; $display("FAIL max_done_stable: idx %0d data %h cm %b expected 121 00640000 1", bus.mem_index, bus.mem_data, bus.mem_change_max); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.mem_written = 1'b1;
      set_req(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
      test_reset();
      test_single_write();
      test_contention();
      test_stale_ack();
      test_reset_mid_wait();
      test_timeout();
      test_max_update();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/upstream_write_arbiter.md
UPSTREAM_WRITE_ARBITER -- requirements
Module: upstream_write_arbiter

Interface
REQ-001 Parameter IDX_W, default 7: client index width, covering 122 upstream entries.
REQ-002 Parameter DATA_W, default 32: write data width; [31:16] is the max field, [15:0] is the accumulated-orders field.
REQ-003 Parameter TIMEOUT, default 15: cycles allowed in WAIT before abort; used only when ARB_TIMEOUT_EN is defined.
REQ-004 Port clk  in  1  single clock; all logic on posedge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port req_valid  in  2  per-requester write request; bit 0 is cache write-back, bit 1 is limit configuration.
REQ-007 Port req_index  in  2*IDX_W  per-requester client index; requester n uses slice n.
REQ-008 Port req_data  in  2*DATA_W  per-requester write data; requester n uses slice n.
REQ-009 Port req_change_max  in  2  per-requester flag: 1 = max update, 0 = accumulate.
REQ-010 Port req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-011 Port req_done  out  2  one-cycle completion pulse.
REQ-012 Port req_err  out  2  one-cycle timeout-abort pulse.
REQ-013 Port mem_rw  out  1  write strobe level to the upstream memory.
REQ-014 Port mem_index  out  IDX_W  latched client index.
REQ-015 Port mem_data  out  DATA_W  latched data.
REQ-016 Port mem_change_max  out  1  latched flag.
REQ-017 Port mem_written  in  1  write-complete level from the memory; drops on a new write, rises when the write is committed.
REQ-018 Port busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE with any req_valid SHALL do all of the following in the same cycle:
- grant one requester;
- pulse req_ready for the granted requester;
- latch that requester's index, data and flag into the mem_* registers;
- go to ISSUE.
REQ-021 Arbitration SHALL be round-robin.
- With one request valid, grant it.
- With both valid, grant the requester that is not last_grant.
- last_grant SHALL update only on the IDLE->ISSUE transition.
REQ-022 ISSUE SHALL drive mem_rw=1, clear the seen_low flag, and go to WAIT the next cycle.
REQ-023 WAIT SHALL hold mem_rw=1.
- mem_written==0 sets seen_low.
- mem_written==1 with seen_low already set goes to DONE.
- A 1 on mem_written before any 0 has been seen SHALL be ignored.
REQ-024 DONE SHALL drive mem_rw=0, pulse req_done for the granted requester, and go to IDLE.
- The next grant cannot occur before the cycle after DONE.
REQ-025 Minimum request-to-done latency SHALL be 4 cycles: accept, ISSUE, WAIT (low), WAIT (high)->DONE.
REQ-026 mem_index, mem_data and mem_change_max SHALL stay stable from ISSUE through DONE.
REQ-027 Requests arriving outside IDLE SHALL NOT be accepted.
- They SHALL be held pending by their requesters.
REQ-028 Data SHALL be forwarded unmodified.
- The arbiter SHALL NOT perform saturation or arithmetic.
REQ-029 Exactly one of req_ready, req_done, req_err SHALL be pulsed per granted transaction phase, and only for the granted bit.

Reset
REQ-030 rst SHALL force, on the next posedge:
- state=IDLE and last_grant=1, so requester 0 wins the first contention;
- seen_low=0, timeout count=0;
- mem_rw=0, mem_index=0, mem_data=0, mem_change_max=0;
- req_ready=0, req_done=0, req_err=0, busy=0.
REQ-031 rst asserted mid-transaction (ISSUE, WAIT or DONE) SHALL abort it.
- No req_done or req_err SHALL be pulsed for the aborted transaction.
- mem_rw SHALL return to 0.
REQ-032 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 With ARB_TIMEOUT_EN defined:
- a counter SHALL clear on ISSUE and increment each WAIT cycle;
- on reaching TIMEOUT in WAIT, the FSM SHALL drop mem_rw, pulse req_err for the granted requester (no req_done) and return to IDLE.
REQ-034 Without ARB_TIMEOUT_EN:
- no counter SHALL exist;
- WAIT SHALL last until the REQ-023 exit condition;
- req_err SHALL be tied to 0.

Verification
REQ-035 Single write. Stimulus: req_valid=01, index 5, data 0x0000_0010, change_max 0; memory drops written and raises it 3 cycles later. Response:
- req_ready[0] in cycle 0;
- mem_rw=1, mem_index=5;
- req_done[0] once written rises after the low;
- busy low afterwards.
REQ-036 Contention after reset. Stimulus: req_valid=11 held for two transactions. Response: grants in order 0, then 1; the second req_ready occurs only after the first req_done.
REQ-037 Stale ack. Stimulus: mem_written held 1 through ISSUE and first WAIT cycle, then 0, then 1. Response: req_done occurs only after the 0->1 sequence.
REQ-038 Reset mid-WAIT. Stimulus: rst for 1 cycle while in WAIT. Response:
- mem_rw=0 and busy=0 next cycle;
- no req_done or req_err pulse;
- the next contention grants requester 0.
REQ-039 Timeout (ARB_TIMEOUT_EN, TIMEOUT=15). Stimulus: mem_written stuck 0. Response: req_err pulses after 15 WAIT cycles, with no req_done; without the macro, busy stays high indefinitely.
REQ-040 Max update passthrough. Stimulus: requester 1, index 121, data 0x0064_0000, change_max 1. Response: mem_data=0x0064_0000, mem_index=121, mem_change_max=1, all stable ISSUE through DONE.
